freq_gate_ctrl: RTL and testbench

- Measurement-window controller that sits directly downstream of the raw input signal and alongside the edge timer.
- Synchronizes the asynchronous measured signal into the system clock domain and detects its rising edges.
- Counts those edges over a fixed gate window of system-clock cycles.
- Latches the total as a frequency result with a valid/ready handshake for the display/readout stage.

---
 rtl/freq_gate_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gated edge counter for frequency measurement.
// The asynchronous input is synchronised, its rising edges are counted over
// a fixed window of GATE_CYCLES clocks, and the total is presented to a
// downstream reader through a valid/ready handshake.
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter bit          CONTINUOUS  = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 start,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 overflow
);

    // Gate counter holds GATE_CYCLES-1 down to 0.
    localparam int unsigned GCW = $clog2(GATE_CYCLES) + 1;
    localparam logic [GCW-1:0] GATE_LOAD = GCW'(GATE_CYCLES - 32'd1);
    localparam logic [GCW-1:0] GATE_ZERO = {GCW{1'b0}};
    localparam logic [GCW-1:0] GATE_ONE  = {{(GCW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Saturating increment: returns {attempted_past_max, new_count}.
    function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        logic [CNT_WIDTH:0] res;
        if (cnt == CNT_MAX) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + CNT_ONE};
        end
        return res;
    endfunction

    // Synchroniser / edge-history flops
    logic s1_r, s2_r, s3_r;
    logic edge_pulse_s;

    // Registered state
    state_t               state_r;
    logic [GCW-1:0]       gate_cnt_r;
    logic [CNT_WIDTH-1:0] edge_cnt_r;
    logic                 ovf_acc_r;
    logic [CNT_WIDTH-1:0] result_r;
    logic                 result_valid_r;
    logic                 overflow_r;
    logic                 busy_r;

    // Next-state values
    state_t               state_nxt_s;
    logic [GCW-1:0]       gate_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] edge_cnt_nxt_s;
    logic                 ovf_acc_nxt_s;
    logic [CNT_WIDTH-1:0] result_nxt_s;
    logic                 result_valid_nxt_s;
    logic                 overflow_nxt_s;
    logic                 busy_nxt_s;

    // Window-accumulation helpers
    logic [CNT_WIDTH:0]   inc_s;
    logic [CNT_WIDTH-1:0] cnt_upd_s;
    logic                 ovf_upd_s;

    assign edge_pulse_s = s2_r & ~s3_r;

    // Two-flop synchroniser plus history flop, running in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Count including this cycle's edge, saturating and flagging overflow.
    always_comb begin
        inc_s = sat_inc(edge_cnt_r);
        if (edge_pulse_s) begin
            cnt_upd_s = inc_s[CNT_WIDTH-1:0];
            ovf_upd_s = ovf_acc_r | inc_s[CNT_WIDTH];
        end else begin
            cnt_upd_s = edge_cnt_r;
            ovf_upd_s = ovf_acc_r;
        end
    end

    // Next-state and next-output logic for the measurement FSM.
    always_comb begin
        state_nxt_s        = state_r;
        gate_cnt_nxt_s     = gate_cnt_r;
        edge_cnt_nxt_s     = edge_cnt_r;
        ovf_acc_nxt_s      = ovf_acc_r;
        result_nxt_s       = result_r;
        result_valid_nxt_s = result_valid_r;
        overflow_nxt_s     = overflow_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_GATE;
                    gate_cnt_nxt_s = GATE_LOAD;
                    edge_cnt_nxt_s = CNT_ZERO;
                    ovf_acc_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GATE: begin
                edge_cnt_nxt_s = cnt_upd_s;
                ovf_acc_nxt_s  = ovf_upd_s;
                if (gate_cnt_r == GATE_ZERO) begin
                    // Last gate cycle: its edge is already in cnt_upd_s.
                    state_nxt_s        = ST_HOLD;
                    result_nxt_s       = cnt_upd_s;
                    overflow_nxt_s     = ovf_upd_s;
                    result_valid_nxt_s = 1'b1;
                end else begin
                    gate_cnt_nxt_s = gate_cnt_r - GATE_ONE;
                end
            end
            ST_HOLD: begin
                if (result_valid_r && result_ready) begin
                    result_valid_nxt_s = 1'b0;
                    if (CONTINUOUS) begin
                        state_nxt_s    = ST_GATE;
                        gate_cnt_nxt_s = GATE_LOAD;
                        edge_cnt_nxt_s = CNT_ZERO;
                        ovf_acc_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle.
                state_nxt_s        = ST_IDLE;
                result_valid_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers; reset discards any window in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            gate_cnt_r     <= GATE_ZERO;
            edge_cnt_r     <= CNT_ZERO;
            ovf_acc_r      <= 1'b0;
            result_r       <= CNT_ZERO;
            result_valid_r <= 1'b0;
            overflow_r     <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            gate_cnt_r     <= gate_cnt_nxt_s;
            edge_cnt_r     <= edge_cnt_nxt_s;
            ovf_acc_r      <= ovf_acc_nxt_s;
            result_r       <= result_nxt_s;
            result_valid_r <= result_valid_nxt_s;
            overflow_r     <= overflow_nxt_s;
            busy_r         <= busy_nxt_s;
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign overflow     = overflow_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Testbench for freq_gate_ctrl: four instances with different parameters,
// directed steps, and a scoreboard of expected results per completed window.
module tb_freq_gate_ctrl;

    typedef struct {
        int idx;
        int res;
        int ovf;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  sig_v;
    logic [3:0]  start_v;
    logic [3:0]  ready_v;
    logic [3:0]  valid_v;
    logic [3:0]  busy_v;
    logic [3:0]  ovf_v;
    logic [31:0] res0, res2, res3;
    logic [3:0]  res1;

    exp_t sbq[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   per[4];
    int   ph[4];
    logic [3:0] lvl;
    logic [3:0] vprev;

    // 0: basic (G=100), 1: 4-bit saturating, 2: continuous (G=50), 3: G=1
    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_WIDTH(32), .CONTINUOUS(1'b0)) u_base (
        .clock(clock), .reset(reset), .sig_in(sig_v[0]), .start(start_v[0]),
        .result(res0), .result_valid(valid_v[0]), .result_ready(ready_v[0]),
        .busy(busy_v[0]), .overflow(ovf_v[0]));
    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_WIDTH(4), .CONTINUOUS(1'b0)) u_sat (
        .clock(clock), .reset(reset), .sig_in(sig_v[1]), .start(start_v[1]),
        .result(res1), .result_valid(valid_v[1]), .result_ready(ready_v[1]),
        .busy(busy_v[1]), .overflow(ovf_v[1]));
    freq_gate_ctrl #(.GATE_CYCLES(50), .CNT_WIDTH(32), .CONTINUOUS(1'b1)) u_cont (
        .clock(clock), .reset(reset), .sig_in(sig_v[2]), .start(start_v[2]),
        .result(res2), .result_valid(valid_v[2]), .result_ready(ready_v[2]),
        .busy(busy_v[2]), .overflow(ovf_v[2]));
    freq_gate_ctrl #(.GATE_CYCLES(1), .CNT_WIDTH(32), .CONTINUOUS(1'b0)) u_one (
        .clock(clock), .reset(reset), .sig_in(sig_v[3]), .start(start_v[3]),
        .result(res3), .result_valid(valid_v[3]), .result_ready(ready_v[3]),
        .busy(busy_v[3]), .overflow(ovf_v[3]));

    function automatic logic [31:0] res_of(input int i);
        case (i)
            0: return res0;
            1: return {28'd0, res1};
            2: return res2;
            default: return res3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int i, input int r, input int o);
        exp_t x;
        x.idx = i;
        x.res = r;
        x.ovf = o;
        sbq.push_back(x);
    endtask

    // One window with ready held high; checks busy length, valid width, latency.
    task automatic run_win(input int i, input int r, input int o, input int g, input string tag);
        int nb;
        int nv;
        int lat;
        nb  = 0;
        nv  = 0;
        lat = 0;
        push(i, r, o);
        start_v[i] = 1'b1;
        for (int k = 1; k <= g + 20; k++) begin
            @(negedge clock);
            if (k == 1) start_v[i] = 1'b0;
            if (busy_v[i]) nb++;
            if (valid_v[i]) begin
                nv++;
                if (lat == 0) lat = k;
            end
        end
        chk({tag, "_busy_cycles"}, nb, g + 1);
        chk({tag, "_valid_cycles"}, nv, 1);
        chk({tag, "_latency"}, lat, g + 1);
        chk({tag, "_idle_after"}, {31'd0, busy_v[i]}, 0);
    endtask

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Input waveform generator: changes 2 time units after each rising edge.
    initial begin
        sig_v = 4'd0;
        for (int i = 0; i < 4; i++) ph[i] = 0;
        forever begin
            @(posedge clock);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (per[i] > 0) begin
                    ph[i]++;
                    if (ph[i] >= per[i] / 2) begin
                        ph[i]    = 0;
                        sig_v[i] = ~sig_v[i];
                    end
                end else begin
                    sig_v[i] = lvl[i];
                end
            end
        end
    end

    // Scoreboard: each rising result_valid pops and checks one expectation.
    initial begin
        vprev = 4'd0;
        forever begin
            @(negedge clock);
            for (int m = 0; m < 4; m++) begin
                if (valid_v[m] && !vprev[m]) begin
                    chk($sformatf("sb_pending_dut%0d", m), (sbq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk($sformatf("sb_idx_dut%0d", m), m, e.idx);
                        chk($sformatf("sb_result_dut%0d", m), res_of(m), e.res);
                        chk($sformatf("sb_overflow_dut%0d", m), {31'd0, ovf_v[m]}, e.ovf);
                    end
                end
                vprev[m] = valid_v[m];
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        int lat;
        int idle_cnt;
        int nv;
        logic pv;

        for (int i = 0; i < 4; i++) per[i] = 0;
        lvl     = 4'b0001;   // dut0 input held high from before reset release
        start_v = 4'd0;
        ready_v = 4'b1111;
        reset   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_result_dut%0d", i), res_of(i), 0);
            chk($sformatf("reset_valid_dut%0d", i), {31'd0, valid_v[i]}, 0);
            chk($sformatf("reset_busy_dut%0d", i), {31'd0, busy_v[i]}, 0);
            chk($sformatf("reset_ovf_dut%0d", i), {31'd0, ovf_v[i]}, 0);
        end
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // No edges: input constantly high
        run_win(0, 0, 0, 100, "no_edges");

        // Basic window, period 10
        per[0] = 10;
        repeat (30) @(negedge clock);
        run_win(0, 10, 0, 100, "basic");

        // Saturation with 4-bit counter, then a normal window
        per[1] = 4;
        repeat (20) @(negedge clock);
        run_win(1, 15, 1, 100, "saturate");
        per[1] = 20;
        repeat (40) @(negedge clock);
        run_win(1, 5, 0, 100, "after_saturate");

        // Backpressure with stray start requests in GATE and HOLD
        ready_v[0] = 1'b0;
        push(0, 10, 0);
        start_v[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clock);
            if (k == 1)  start_v[0] = 1'b0;
            if (k == 50) start_v[0] = 1'b1;
            if (k == 51) start_v[0] = 1'b0;
            if (valid_v[0] && lat == 0) lat = k;
        end
        chk("bp_latency", lat, 101);
        for (int j = 1; j <= 20; j++) begin
            if (j == 5) start_v[0] = 1'b1;
            if (j == 6) start_v[0] = 1'b0;
            chk("bp_hold_result", res0, 10);
            chk("bp_hold_valid", {31'd0, valid_v[0]}, 1);
            chk("bp_hold_busy", {31'd0, busy_v[0]}, 1);
            @(negedge clock);
        end
        ready_v[0] = 1'b1;
        @(negedge clock);
        chk("bp_valid_cleared", {31'd0, valid_v[0]}, 0);
        chk("bp_idle", {31'd0, busy_v[0]}, 0);
        idle_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (!busy_v[0]) idle_cnt++;
        end
        chk("bp_start_not_queued", idle_cnt, 10);
        chk("bp_result_kept", res0, 10);

        // Continuous mode: one start, back-to-back windows
        per[2] = 10;
        repeat (30) @(negedge clock);
        for (int j = 0; j < 4; j++) push(2, 5, 0);
        start_v[2] = 1'b1;
        idle_cnt = 0;
        nv = 0;
        pv = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clock);
            if (k == 1)   start_v[2] = 1'b0;
            if (k == 155) ready_v[2] = 1'b0;
            if (k <= 153 && !busy_v[2]) idle_cnt++;
            if (valid_v[2] && !pv) nv++;
            pv = valid_v[2];
        end
        chk("cont_no_idle", idle_cnt, 0);
        chk("cont_three_results", nv, 3);
        repeat (60) @(negedge clock);
        chk("cont_fourth_held", {31'd0, valid_v[2]}, 1);
        chk("cont_busy", {31'd0, busy_v[2]}, 1);

        // Reset in the middle of a gate window
        start_v[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) start_v[0] = 1'b0;
        end
        chk("mid_gate_busy", {31'd0, busy_v[0]}, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy_v[0]}, 0);
        chk("rst_result", res0, 0);
        chk("rst_valid", {31'd0, valid_v[0]}, 0);
        chk("rst_cont_valid", {31'd0, valid_v[2]}, 0);
        chk("rst_cont_busy", {31'd0, busy_v[2]}, 0);
        repeat (20) @(negedge clock);
        run_win(0, 10, 0, 100, "after_reset");

        // Single-cycle gate: no edge, then one edge inside the gate cycle
        run_win(3, 0, 0, 1, "g1_zero");
        lvl[3] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        run_win(3, 1, 0, 1, "g1_one");

        repeat (5) @(negedge clock);
        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
